// File: rtl/bf_sbox_feistel_unit.sv
// Blowfish F-function engine: F(x) = ((S0[a] + S1[b]) ^ S2[c]) + S3[d] over four runtime-loadable S-boxes.
// Latency: 3 cycles with OUT_REG=1 (RAM read, mix, output add), 2 cycles with OUT_REG=0.
// Backpressure: valid/ready; a full stage holds while its successor is blocked, bubbles collapse; wr_en blocks input.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data  S-box write port (key schedule side)
//   in_valid/in_ready/in_data     lookup request, in_data = {a, b, c, d} MSB first
//   out_valid/out_ready/out_data  F result stream (round datapath side)
//   busy                          any pipeline stage holds a valid lookup
module bf_sbox_feistel_unit #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 8,
  parameter int OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [1:0]           wr_sel,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*IDX_W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 busy
);

  localparam int DEPTH    = 1 << IDX_W;
  localparam bit USE_OREG = (OUT_REG != 0);

  // Box storage and the synchronous read registers (stage 1 data).
  // Neither is reset: contents are owned by the key schedule.
  logic [DATA_W-1:0] mem  [4][DEPTH];
  logic [DATA_W-1:0] rd_q [4];

  // Stage valid bits and data registers
  logic              rdy_q, rdy_d;
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic              v3_q, v3_d;
  logic [DATA_W-1:0] mix_q, mix_d;
  logic [DATA_W-1:0] s3_q, s3_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic s1_free, s2_free, s3_free;
  logic rd_en;

  // A stage may load when it is empty or its contents move on this edge.
  // Stage 1 is therefore blocked only when every stage is full and the
  // output is stalled.
  always_comb begin
    s3_free = !v3_q || out_ready;
    s2_free = !v2_q || (USE_OREG ? s3_free : out_ready);
    s1_free = !v1_q || s2_free;
  end

  // wr_en forces in_ready low, so a read and a write never share an edge
  // and an accepted lookup always sees the contents as of its own edge.
  assign in_ready = rdy_q && !wr_en && s1_free;
  assign rd_en    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_sel][wr_addr] <= wr_data;
    end
    // Read enable is gated to accepts only, so held stage-1 data is never
    // disturbed by a stall or by a later write.
    if (rd_en) begin
      for (int i = 0; i < 4; i++) begin
        rd_q[i] <= mem[i][in_data[(4-i)*IDX_W-1 -: IDX_W]];
      end
    end
  end

  always_comb begin
    rdy_d = 1'b1;
    v1_d  = rd_en || (v1_q && !s2_free);

    v2_d  = v2_q;
    mix_d = mix_q;
    s3_d  = s3_q;
    if (s2_free) begin
      v2_d = v1_q;
      if (v1_q) begin
        // Carry out of the first sum is dropped by the DATA_W-wide result.
        mix_d = (rd_q[0] + rd_q[1]) ^ rd_q[2];
        s3_d  = rd_q[3];
      end
    end

    v3_d  = v3_q;
    out_d = out_q;
    if (USE_OREG && s3_free) begin
      v3_d = v2_q;
      // Data loads only with a valid result so out_data holds when idle.
      if (v2_q) begin
        out_d = mix_q + s3_q;
      end
    end
    if (!USE_OREG) begin
      v3_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      mix_q <= '0;
      s3_q  <= '0;
      out_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      mix_q <= mix_d;
      s3_q  <= s3_d;
      out_q <= out_d;
    end
  end

  assign out_valid = USE_OREG ? v3_q : v2_q;
  assign out_data  = USE_OREG ? out_q : (mix_q + s3_q);
  assign busy      = v1_q || v2_q || v3_q;

endmodule

// File: tb/tb_bf_sbox_feistel_unit.sv
// Directed bench for bf_sbox_feistel_unit (default parameters, OUT_REG=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled either
// there or on the falling edge. A negedge monitor collects every transfer.
module tb_bf_sbox_feistel_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  always #5 clk = ~clk;

  bf_sbox_feistel_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_cyc = 0;
  logic [31:0] got_q[$];
  int          got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sbox_wr(input logic [1:0] s, input logic [7:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_sel  = s;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) acc_cyc = cyc;
      step();
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < 60 && got_q.size() < n; i++) step();
    check("result_count", got_q.size(), n);
  endtask

  task automatic clear();
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1);
  end

  initial begin
    bit rdy_ok;
    int first_acc;

    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = 2'd0;
    wr_addr   = 8'd0;
    wr_data   = 32'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("ready_after_rst", in_ready, 32'd1);

    // 1: basic F, (1+2)^4 + 0x10 = 0x17, three cycles after acceptance
    sbox_wr(2'd0, 8'h01, 32'h00000001);
    sbox_wr(2'd1, 8'h02, 32'h00000002);
    sbox_wr(2'd2, 8'h03, 32'h00000004);
    sbox_wr(2'd3, 8'h04, 32'h00000010);
    clear();
    send(32'h01020304);
    wait_n(1);
    check("t1_data", got_q[0], 32'h00000017);
    check("t1_latency", got_cyc[0] - acc_cyc, 32'd3);

    // 2: both additions wrap mod 2^32
    sbox_wr(2'd0, 8'h00, 32'hFFFFFFFF);
    sbox_wr(2'd1, 8'h00, 32'h00000002);
    sbox_wr(2'd2, 8'h00, 32'h00000000);
    sbox_wr(2'd3, 8'h00, 32'hFFFFFFFF);
    clear();
    send(32'h00000000);
    wait_n(1);
    check("t2_wrap", got_q[0], 32'h00000000);

    // 3: 8 back-to-back lookups; ((i + 0x100) ^ 0xF0) + 0x1000 = 0x11F0 + i
    for (int i = 0; i < 8; i++) sbox_wr(2'd0, 8'h10 + 8'(i), 32'(i));
    sbox_wr(2'd1, 8'h20, 32'h00000100);
    sbox_wr(2'd2, 8'h30, 32'h000000F0);
    sbox_wr(2'd3, 8'h40, 32'h00001000);
    clear();
    rdy_ok    = 1'b1;
    first_acc = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h10203040 + (32'(i) << 24);
      @(negedge clk);
      if (!in_ready) rdy_ok = 1'b0;
      if (i == 0) first_acc = cyc;
      step();
    end
    in_valid = 1'b0;
    wait_n(8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_data%0d", i), got_q[i], 32'h000011F0 + 32'(i));
    check("t3_consecutive", got_cyc[7] - got_cyc[0], 32'd7);
    check("t3_in_ready_held", rdy_ok, 32'd1);
    check("t3_latency", got_cyc[0] - first_acc, 32'd3);

    // 4: stall with 3 accepted lookups filling the pipeline
    clear();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h10203040 + (32'(i) << 24));
    check("t4_in_ready_low", in_ready, 32'd0);
    check("t4_out_valid", out_valid, 32'd1);
    check("t4_head", out_data, 32'h000011F0);
    repeat (3) step();
    check("t4_hold", out_data, 32'h000011F0);
    check("t4_in_ready_still_low", in_ready, 32'd0);
    check("t4_none_taken", got_q.size(), 32'd0);
    out_ready = 1'b1;
    wait_n(3);
    for (int i = 0; i < 3; i++) check($sformatf("t4_data%0d", i), got_q[i], 32'h000011F0 + 32'(i));
    repeat (3) step();
    check("t4_no_dup", got_q.size(), 32'd3);
    check("t4_busy_idle", busy, 32'd0);

    // 5: write after acceptance does not disturb the in-flight lookup
    clear();
    send(32'h01020304);
    wr_en   = 1'b1;
    wr_sel  = 2'd3;
    wr_addr = 8'h04;
    wr_data = 32'h00000100;
    #1 check("t5_in_ready_on_write", in_ready, 32'd0);
    step();
    wr_en = 1'b0;
    send(32'h01020304);
    wait_n(2);
    check("t5_old_contents", got_q[0], 32'h00000017);
    check("t5_new_contents", got_q[1], 32'h00000107);

    // 6: reset with two lookups in flight; boxes survive reset
    sbox_wr(2'd3, 8'h04, 32'h00000010);
    clear();
    send(32'h01020304);
    send(32'h10203040);
    check("t6_busy_before", busy, 32'd1);
    rst_n = 1'b0;
    step();
    check("t6_out_valid", out_valid, 32'd0);
    check("t6_busy", busy, 32'd0);
    check("t6_in_ready_in_rst", in_ready, 32'd0);
    rst_n = 1'b1;
    step();
    check("t6_no_stale", got_q.size(), 32'd0);
    send(32'h01020304);
    wait_n(1);
    check("t6_retained", got_q[0], 32'h00000017);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
